// File: rtl/dcache_pkg.sv
// Shared data-cache replacement types: default geometry, index/age typedefs, sweep FSM states.
package dcache_pkg;

  localparam int unsigned NUM_WAYS  = 4;
  localparam int unsigned NUM_SETS  = 64;
  localparam int unsigned AGE_WIDTH = NUM_WAYS - 1;
  localparam int unsigned WAY_WIDTH = $clog2(NUM_WAYS);
  localparam int unsigned SET_WIDTH = $clog2(NUM_SETS);

  typedef logic [SET_WIDTH-1:0] set_idx_t;
  typedef logic [WAY_WIDTH-1:0] way_idx_t;
  typedef logic [AGE_WIDTH-1:0] age_bits_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/plru_state_array_plru.sv
// Tree-PLRU decoder: heap-ordered age bits (1 = LRU on the right) -> victim way, plus touch update.
module plru #(
  parameter  int unsigned NUM_WAYS   = 4,
  localparam int unsigned AGE_WIDTH  = NUM_WAYS - 1,
  localparam int unsigned WAY_WIDTH  = $clog2(NUM_WAYS),
  localparam int unsigned NODE_WIDTH = WAY_WIDTH + 1
) (
  input  logic [AGE_WIDTH-1:0] age_bits_i,
  input  logic [WAY_WIDTH-1:0] access_way_i,
  output logic [WAY_WIDTH-1:0] victim_way_o,
  output logic [AGE_WIDTH-1:0] age_bits_next_o
);

  logic [NODE_WIDTH-1:0] dec_node;
  logic [NODE_WIDTH-1:0] upd_node;
  logic [WAY_WIDTH-1:0]  upd_path;
  logic                  dec_bit;

  // Follow the age bits from the root; each visited bit is one victim-way bit, MSB first.
  always_comb begin
    dec_node     = '0;
    dec_bit      = 1'b0;
    victim_way_o = '0;
    for (int lvl = 0; lvl < int'(WAY_WIDTH); lvl++) begin
      dec_bit = 1'b0;
      for (int k = 0; k < int'(AGE_WIDTH); k++) begin
        if (dec_node == NODE_WIDTH'(k)) dec_bit = age_bits_i[k];
      end
      victim_way_o = (victim_way_o << 1) | WAY_WIDTH'(dec_bit);
      dec_node     = (dec_node << 1) + (dec_bit ? NODE_WIDTH'(2) : NODE_WIDTH'(1));
    end
  end

  // Point every node on the accessed way's path away from that way.
  always_comb begin
    age_bits_next_o = age_bits_i;
    upd_node        = '0;
    upd_path        = access_way_i;
    for (int lvl = 0; lvl < int'(WAY_WIDTH); lvl++) begin
      for (int k = 0; k < int'(AGE_WIDTH); k++) begin
        if (upd_node == NODE_WIDTH'(k)) age_bits_next_o[k] = ~upd_path[WAY_WIDTH-1];
      end
      upd_node = (upd_node << 1) + (upd_path[WAY_WIDTH-1] ? NODE_WIDTH'(2) : NODE_WIDTH'(1));
      upd_path = upd_path << 1;
    end
  end

endmodule

// File: rtl/plru_state_array.sv
// Per-set tree-PLRU age storage with post-reset clearing sweep and write-first victim lookup.
module plru_state_array
  import dcache_pkg::sweep_state_e;
  import dcache_pkg::ST_INIT;
  import dcache_pkg::ST_RUN;
#(
  parameter  int unsigned NUM_WAYS   = dcache_pkg::NUM_WAYS,
  parameter  int unsigned NUM_SETS   = dcache_pkg::NUM_SETS,
  localparam int unsigned AGE_WIDTH  = NUM_WAYS - 1,
  localparam int unsigned WAY_WIDTH  = $clog2(NUM_WAYS),
  localparam int unsigned SET_WIDTH  = $clog2(NUM_SETS),
  localparam int unsigned NODE_WIDTH = WAY_WIDTH + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 ready_o,
  input  logic                 lookup_valid_i,
  input  logic [SET_WIDTH-1:0] lookup_set_i,
  output logic                 victim_valid_o,
  output logic [WAY_WIDTH-1:0] victim_way_o,
  input  logic                 touch_valid_i,
  input  logic [SET_WIDTH-1:0] touch_set_i,
  input  logic [WAY_WIDTH-1:0] touch_way_i
);

  sweep_state_e          state_q, state_d;
  logic [SET_WIDTH-1:0]  sweep_cnt_q, sweep_cnt_d;
  logic                  ready_q, ready_d;
  logic                  victim_valid_q, victim_valid_d;
  logic [WAY_WIDTH-1:0]  victim_way_q, victim_way_d;
  logic [AGE_WIDTH-1:0]  age_q [NUM_SETS];
  logic [AGE_WIDTH-1:0]  age_d [NUM_SETS];

  logic                  lookup_acc;
  logic                  touch_acc;
  logic [AGE_WIDTH-1:0]  touch_bits;
  logic [AGE_WIDTH-1:0]  lookup_bits;
  logic [WAY_WIDTH-1:0]  plru_victim;

  // New age bits for a touched way: path nodes point away from it, others untouched.
  function automatic logic [AGE_WIDTH-1:0] touch_update(input logic [AGE_WIDTH-1:0] bits,
                                                        input logic [WAY_WIDTH-1:0] way);
    logic [AGE_WIDTH-1:0]  res;
    logic [NODE_WIDTH-1:0] node;
    logic [WAY_WIDTH-1:0]  path;
    res  = bits;
    node = '0;
    path = way;
    for (int lvl = 0; lvl < int'(WAY_WIDTH); lvl++) begin
      for (int k = 0; k < int'(AGE_WIDTH); k++) begin
        if (node == NODE_WIDTH'(k)) res[k] = ~path[WAY_WIDTH-1];
      end
      node = (node << 1) + (path[WAY_WIDTH-1] ? NODE_WIDTH'(2) : NODE_WIDTH'(1));
      path = path << 1;
    end
    return res;
  endfunction

  assign lookup_acc  = lookup_valid_i && ready_q;
  assign touch_acc   = touch_valid_i && ready_q;
  assign touch_bits  = touch_update(age_q[touch_set_i], touch_way_i);
  // Write-first: a same-set touch in this cycle is visible to this cycle's lookup.
  assign lookup_bits = (touch_acc && (touch_set_i == lookup_set_i)) ? touch_bits
                                                                    : age_q[lookup_set_i];

  plru #(
    .NUM_WAYS(NUM_WAYS)
  ) u_plru (
    .age_bits_i     (lookup_bits),
    .access_way_i   (touch_way_i),
    .victim_way_o   (plru_victim),
    .age_bits_next_o()
  );

  // Next-state: sweep clears one set per cycle in INIT; RUN serves lookups and touches.
  always_comb begin
    state_d        = state_q;
    sweep_cnt_d    = sweep_cnt_q;
    ready_d        = ready_q;
    victim_valid_d = lookup_acc;
    victim_way_d   = lookup_acc ? plru_victim : victim_way_q;
    age_d          = age_q;
    case (state_q)
      ST_INIT: begin
        age_d[sweep_cnt_q] = '0;
        sweep_cnt_d        = sweep_cnt_q + SET_WIDTH'(1);
        if (sweep_cnt_q == SET_WIDTH'(NUM_SETS - 1)) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (touch_acc) age_d[touch_set_i] = touch_bits;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Control and output registers with synchronous reset back into the sweep.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_INIT;
      sweep_cnt_q    <= '0;
      ready_q        <= 1'b0;
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
    end else begin
      state_q        <= state_d;
      sweep_cnt_q    <= sweep_cnt_d;
      ready_q        <= ready_d;
      victim_valid_q <= victim_valid_d;
      victim_way_q   <= victim_way_d;
    end
  end

  // Age storage is cleared by the sweep rather than by reset.
  always_ff @(posedge clk_i) begin
    age_q <= age_d;
  end

  assign ready_o        = ready_q;
  assign victim_valid_o = victim_valid_q;
  assign victim_way_o   = victim_way_q;

endmodule
